logic_proc_control: RTL

- Control unit for the 8-bit bit-serial logic processor.
- Sequences the A/B shift registers, the per-bit function unit and the A/B write-back router.
- Decodes the operator Execute/LoadA/LoadB controls into:
  - register load strobes,
  - a shift enable lasting exactly DATA_W cycles,
  - stable, latched function/route selects.
- Sits between the operator switch/button inputs and the register/compute/router datapath.

---
 rtl/logic_proc_control.sv | 94 +++++++++
 1 files changed

// File: rtl/logic_proc_control.sv
// Control unit for the bit-serial logic processor: sequences register loads,
// a DATA_W-cycle shift burst and latched function/route selects.
module logic_proc_control #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Execute,
  input  logic       LoadA,
  input  logic       LoadB,
  input  logic [2:0] F_In,
  input  logic [1:0] R_In,
  output logic       Ld_A,
  output logic       Ld_B,
  output logic       Shift_En,
  output logic [2:0] F_Sel,
  output logic [1:0] R_Sel,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             latch;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      count <= '0;
      F_Sel <= '0;
      R_Sel <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (latch) begin
        F_Sel <= F_In;
        R_Sel <= R_In;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    latch     = 1'b0;
    Ld_A      = 1'b0;
    Ld_B      = 1'b0;
    Shift_En  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        // Execute takes priority over the load strobes in the same cycle
        Ld_A = LoadA & ~Execute;
        Ld_B = LoadB & ~Execute;
        if (Execute) begin
          latch     = 1'b1;
          count_nxt = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        if (count == LAST) begin
          count_nxt = '0;
          state_nxt = HOLD;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      HOLD: begin
        Done      = 1'b1;
        Busy      = 1'b1;
        count_nxt = '0;
        if (!Execute) state_nxt = IDLE;
      end
      default: begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
